pipe_stage_chain: RTL

//  Parametrised chain of inter-stage pipeline registers with valid tracking, elastic valid/ready

---
 rtl/pipe_stage_chain_pkg.sv | 28 ++
 rtl/pipe_stage_chain_stage.sv | 58 +++++
 rtl/pipe_stage_chain.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pipe_stage_chain_pkg.sv
// Shared definitions for the inter-stage pipeline register chain: bubble
// control value, control-bit positions and the occupancy width helper.
package pipe_pkg;

    // Default control width; modules cast CTRL_BUBBLE to their own CTRL_W.
    localparam int CTRL_W_DEF = 10;

    // A bubble carries all-zero control so no write enable leaks downstream.
    localparam logic [CTRL_W_DEF-1:0] CTRL_BUBBLE = '0;

    // Control-bit positions inside a stage's control word.
    localparam int REGDST    = 0;
    localparam int JUMP      = 1;
    localparam int BRANCH    = 2;
    localparam int MEMREAD   = 3;
    localparam int MEMTOREG  = 4;
    localparam int MEMWRITE  = 5;
    localparam int ALUSRC    = 6;
    localparam int REGWRITE  = 7;
    localparam int ALUOP_LSB = 8;
    localparam int ALUOP_W   = 2;

    // Width of a counter that holds 0..depth.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage_chain_stage.sv
// One pipeline slot: valid bit, payload and control. Priority is
// rst > flush > load > drain; stall is resolved by the parent, which never
// asserts load or drain for a stalled slot.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              load,
    input  logic              drain,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              v,
    output logic              v_next,
    output logic [WIDTH-1:0]  data,
    output logic [CTRL_W-1:0] ctrl
);

    // Next valid state, exported so the parent can register occupancy alongside v.
    always_comb begin
        // NOTE: default assignment first so every path assigns v_next; no latch is inferred.
        v_next = v;
        if (rst || flush) begin
            v_next = 1'b0;
        end else if (load) begin
            v_next = 1'b1;
        end else if (drain) begin
            v_next = 1'b0;
        end
    end

    // Valid register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        v <= v_next;
    end

    // Payload and control: bubbles zero the control, the payload just holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: payload is a few flops, not a RAM, so it is reset too for clean observability.
            data <= '0;
            ctrl <= CTRL_W'(CTRL_BUBBLE);
        end else if (flush) begin
            ctrl <= CTRL_W'(CTRL_BUBBLE);
        end else if (load) begin
            data <= in_data;
            ctrl <= in_ctrl;
        end else if (drain) begin
            ctrl <= CTRL_W'(CTRL_BUBBLE);
        end
    end

endmodule

// File: rtl/pipe_stage_chain.sv
// Elastic chain of DEPTH pipeline registers with valid/ready backpressure,
// per-stage stall and flush. Optional performance counters are enabled by
// defining PIPE_STAGE_CHAIN_PERF_EN.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [CTRL_W-1:0]         in_ctrl,
    input  logic [DEPTH-1:0]          stall,
    input  logic [DEPTH-1:0]          flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [CTRL_W-1:0]         out_ctrl,
    output logic [DEPTH-1:0]          stage_valid,
    output logic [DEPTH*CTRL_W-1:0]   stage_ctrl,
    output logic [occ_w(DEPTH)-1:0]   occupancy
`ifdef PIPE_STAGE_CHAIN_PERF_EN
    ,
    output logic [15:0]               perf_retired,
    output logic [15:0]               perf_bubbles
`endif
);

    localparam int OCC_W = occ_w(DEPTH);

    logic [DEPTH:0]    acc;
    logic [DEPTH-1:0]  mv;
    logic [DEPTH-1:0]  load;
    logic [DEPTH-1:0]  v_q;
    logic [DEPTH-1:0]  v_next;
    logic [WIDTH-1:0]  data_q [DEPTH];
    logic [CTRL_W-1:0] ctrl_q [DEPTH];
    logic [OCC_W-1:0]  occ_next;

    // Ready ripples back from the output; a slot moves when it is valid, unstalled and downstream accepts.
    always_comb begin
        acc  = '0;
        mv   = '0;
        load = '0;
        acc[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            mv[i]  = v_q[i] & ~stall[i] & acc[i+1];
            acc[i] = ~stall[i] & (~v_q[i] | mv[i]);
        end
        load[0] = acc[0] & in_valid;
        for (int i = 1; i < DEPTH; i++) begin
            load[i] = mv[i-1];
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0]  src_data;
        logic [CTRL_W-1:0] src_ctrl;

        if (i == 0) begin : g_src_in
            assign src_data = in_data;
            assign src_ctrl = in_ctrl;
        end else begin : g_src_prev
            assign src_data = data_q[i-1];
            assign src_ctrl = ctrl_q[i-1];
        end

        pipe_stage #(
            .WIDTH  (WIDTH),
            .CTRL_W (CTRL_W)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .flush   (flush[i]),
            .load    (load[i]),
            .drain   (mv[i]),
            .in_data (src_data),
            .in_ctrl (src_ctrl),
            .v       (v_q[i]),
            .v_next  (v_next[i]),
            .data    (data_q[i]),
            .ctrl    (ctrl_q[i])
        );

        assign stage_ctrl[i*CTRL_W +: CTRL_W] = ctrl_q[i];
    end

    // Population count of the next valid vector, registered in step with the slots.
    always_comb begin
        occ_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_next = occ_next + OCC_W'(v_next[i]);
        end
    end

    // Occupancy register.
    always_ff @(posedge clk) begin
        if (rst) begin
            occupancy <= '0;
        end else begin
            occupancy <= occ_next;
        end
    end

    assign in_ready    = acc[0];
    assign stage_valid = v_q;
    assign out_valid   = v_q[DEPTH-1] & ~stall[DEPTH-1];
    assign out_data    = data_q[DEPTH-1];
    assign out_ctrl    = out_valid ? ctrl_q[DEPTH-1] : CTRL_W'(CTRL_BUBBLE);

`ifdef PIPE_STAGE_CHAIN_PERF_EN
    // Saturating counters of retired items and of output cycles starved while downstream was ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_retired <= '0;
            perf_bubbles <= '0;
        end else begin
            if (out_valid && out_ready && perf_retired != 16'hFFFF) begin
                perf_retired <= perf_retired + 16'd1;
            end
            if (!out_valid && out_ready && perf_bubbles != 16'hFFFF) begin
                perf_bubbles <= perf_bubbles + 16'd1;
            end
        end
    end
`endif

endmodule
